// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank.
// Counter width is one bit wider than the half-cycle width.
package clk_div_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int NUM_CH_MAX = 16;
  localparam int CNT_W1_DEF = CNT_W_DEF + 1;

  function automatic int cnt_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Bank-wide control/status bundle for clk_div_bank.
// master drives half values and strobes; slave is the divider.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);

  logic [NUM_CH*CNT_W-1:0] half_cycle;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       load_ack;

  modport master (
    output half_cycle, load, enable,
    input  clk_out, tick, load_ack
  );

  modport slave (
    input  half_cycle, load, enable,
    output clk_out, tick, load_ack
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: active/shadow half value, wrap-aligned
// reload, registered 50% clock, rising-edge tick and load ack.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] half_cycle,
  input  logic             load,
  input  logic             enable,
  output logic             clk_out,
  output logic             tick,
  output logic             load_ack
);

  localparam int CW = cnt_w(CNT_W);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] s_q;
  logic             p_q;
  logic [CW-1:0]    c_q;

  logic [CW-1:0] h_x;
  logic [CW-1:0] d;
  logic          run;
  logic          wrap;
  logic          apply;
  logic          co_d;

  assign h_x   = {1'b0, h_q};
  assign d     = {h_q, 1'b0};
  assign run   = enable && (h_q != '0);
  assign wrap  = run && (c_q == d);
  // idle channels take a pending value at once; running ones at wrap
  assign apply = p_q && (!run || wrap);
  assign co_d  = run && (c_q > h_x);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      s_q      <= '0;
      p_q      <= 1'b0;
      c_q      <= ONE;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      clk_out  <= co_d;
      tick     <= co_d & ~clk_out;
      load_ack <= apply;
      c_q      <= (!run || wrap) ? ONE : c_q + ONE;
      if (apply) begin
        h_q <= s_q;
      end
      if (load) begin
        s_q <= half_cycle;
        p_q <= 1'b1;
      end else if (apply) begin
        p_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers
// sharing one input clock.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH*CNT_W-1:0] half_cycle,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       load_ack
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .half_cycle (half_cycle[i*CNT_W +: CNT_W]),
      .load       (load[i]),
      .enable     (enable[i]),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .load_ack   (load_ack[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: per-cycle scoreboard
// model plus table-driven patterns and corner-case sequences.
module tb_clk_div_bank;

  localparam int N = 4;
  localparam int W = 8;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  clk_div_bank_if #(.NUM_CH(N), .CNT_W(W)) bus ();

  clk_div_bank #(
    .NUM_CH (N),
    .CNT_W  (W)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .half_cycle (bus.half_cycle),
    .load       (bus.load),
    .enable     (bus.enable),
    .clk_out    (bus.clk_out),
    .tick       (bus.tick),
    .load_ack   (bus.load_ack)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef logic [3*N-1:0] obs_t;
  obs_t sbq[$];

  int mh[N];
  int ms[N];
  int mc[N];
  bit mp[N];
  bit mco[N];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc++;

  // reference model, stepped on every active edge
  always @(posedge clk_in or negedge rst_n) begin
    logic [N-1:0] e_clk, e_tick, e_ack;
    bit idle, nco, wr, ap;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mh[i] = 0; ms[i] = 0; mc[i] = 1;
        mp[i] = 0; mco[i] = 0;
      end
      sbq.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        idle = !bus.enable[i] || mh[i] == 0;
        if (idle) begin
          nco = 0; ap = mp[i]; mc[i] = 1;
        end else begin
          nco = mc[i] > mh[i];
          wr  = mc[i] == 2 * mh[i];
          ap  = wr && mp[i];
          mc[i] = wr ? 1 : mc[i] + 1;
        end
        e_tick[i] = nco && !mco[i];
        e_clk[i]  = nco;
        e_ack[i]  = ap;
        mco[i]    = nco;
        if (ap) begin mh[i] = ms[i]; mp[i] = 0; end
        if (bus.load[i]) begin
          ms[i] = int'(bus.half_cycle[i*W +: W]);
          mp[i] = 1;
        end
      end
      sbq.push_back({e_clk, e_tick, e_ack});
    end
  end

  always @(negedge clk_in) begin
    obs_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("scoreboard", 32'({bus.clk_out, bus.tick, bus.load_ack}), 32'(e));
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_load(int ch, logic [W-1:0] v);
    bus.half_cycle[ch*W +: W] = v;
    bus.load[ch] = 1'b1;
    @(negedge clk_in);
    bus.load[ch] = 1'b0;
  endtask

  task automatic wait_ack(int ch, string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (bus.load_ack[ch]) break;
    end
    chk(name, 32'(k < 40), 32'd1);
  endtask

  task automatic collect(int ch, int n, output logic [31:0] pat,
                         output int ticks, output int acks);
    pat = '0; ticks = 0; acks = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      pat = {pat[30:0], bus.clk_out[ch]};
      ticks += int'(bus.tick[ch]);
      acks  += int'(bus.load_ack[ch]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #1 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] h;
    logic [15:0]  pat;
    int           ticks;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [31:0] pat;
    int tk, ak, t1, hits;
    tv[0] = '{8'd1, 16'h5555, 8};
    tv[1] = '{8'd2, 16'h3333, 4};
    tv[2] = '{8'd3, 16'h1C71, 3};
    tv[3] = '{8'd4, 16'h0F0F, 2};
    tv[4] = '{8'd0, 16'h0000, 0};

    bus.half_cycle = '0;
    bus.load       = '0;
    bus.enable     = '0;

    cycles(2);
    chk("reset_state", 32'({bus.clk_out, bus.tick, bus.load_ack}), 32'd0);
    rst_n = 1'b1;

    bus.enable[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      do_load(0, tv[i].h);
      wait_ack(0, "tbl_ack");
      collect(0, 16, pat, tk, ak);
      chk("tbl_pattern", pat, 32'(tv[i].pat));
      chk("tbl_ticks", 32'(tk), 32'(tv[i].ticks));
      chk("tbl_no_ack", 32'(ak), 32'd0);
    end
    bus.enable[0] = 1'b0;

    // H=3 running, reload 5 mid-period
    do_reset();
    bus.enable[1] = 1'b1;
    do_load(1, 8'd3);
    wait_ack(1, "h3_ack");
    t1 = cyc;
    cycles(2);
    do_load(1, 8'd5);
    wait_ack(1, "h5_ack");
    chk("h5_gap", 32'(cyc - t1), 32'd6);
    collect(1, 10, pat, tk, ak);
    chk("h5_pattern", pat, 32'h01F);
    bus.enable[1] = 1'b0;

    // two loads in one period, then a load on the wrap cycle
    bus.enable[2] = 1'b1;
    do_load(2, 8'd2);
    wait_ack(2, "h2_ack");
    t1 = cyc;
    do_load(2, 8'd4);
    do_load(2, 8'd7);
    wait_ack(2, "h7_ack");
    chk("h7_gap", 32'(cyc - t1), 32'd4);
    collect(2, 14, pat, tk, ak);
    chk("h7_pattern", pat, 32'h007F);
    chk("h7_single_ack", 32'(ak), 32'd0);
    do_load(2, 8'd6);
    cycles(12);
    do_load(2, 8'd3);
    chk("wrap_load_ack", 32'(bus.load_ack[2]), 32'd1);
    t1 = cyc;
    wait_ack(2, "wrap_next_ack");
    chk("wrap_next_gap", 32'(cyc - t1), 32'd12);
    collect(2, 6, pat, tk, ak);
    chk("h3_after_wrap", pat, 32'h07);
    bus.enable[2] = 1'b0;

    // drop enable during the high phase, then restart
    do_reset();
    bus.enable[3] = 1'b1;
    do_load(3, 8'd2);
    wait_ack(3, "en_ack");
    cycles(3);
    chk("en_high", 32'(bus.clk_out[3]), 32'd1);
    bus.enable[3] = 1'b0;
    cycles(1);
    chk("en_drop", 32'({bus.clk_out[3], bus.tick[3]}), 32'd0);
    cycles(2);
    bus.enable[3] = 1'b1;
    collect(3, 4, pat, tk, ak);
    chk("en_restart", pat, 32'h3);
    chk("en_restart_tick", 32'(tk), 32'd1);

    // asynchronous reset mid-period on every channel
    do_reset();
    bus.enable = '1;
    for (int i = 0; i < N; i++) bus.half_cycle[i*W +: W] = 8'd3;
    bus.load = '1;
    @(negedge clk_in);
    bus.load = '0;
    wait_ack(0, "all_ack");
    cycles(4);
    chk("all_high", 32'(bus.clk_out), 32'hF);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({bus.clk_out, bus.tick, bus.load_ack}), 32'd0);
    cycles(1);
    rst_n = 1'b1;
    hits = 0;
    repeat (8) begin
      @(negedge clk_in);
      hits += int'(|{bus.clk_out, bus.tick, bus.load_ack});
    end
    chk("post_reset_idle", 32'(hits), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of each half-cycle value.
REQ-003 SHALL have port clk_in  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port half_cycle  input  NUM_CH*CNT_W  per-channel half period in clk_in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-006 SHALL have port load  input  NUM_CH  per-channel strobe that captures half_cycle[i] into the shadow register.
REQ-007 SHALL have port enable  input  NUM_CH  per-channel run enable.
REQ-008 SHALL have port clk_out  output  NUM_CH  divided clock per channel, registered.
REQ-009 SHALL have port tick  output  NUM_CH  one-cycle pulse coincident with each 0->1 transition of clk_out[i].
REQ-010 SHALL have port load_ack  output  NUM_CH  one-cycle pulse when a shadow value becomes active.

Function
REQ-011 Each channel SHALL hold an active half value H, a shadow value S, a pending flag P and a counter C (CNT_W+1 bits).
REQ-012 The period SHALL be D = 2*H, computed at CNT_W+1 bits so that no overflow occurs for H = 2^CNT_W-1.
REQ-013 With enable=1 and H>0, C SHALL count 1,2,...,D and then wrap to 1, advancing once per clk_in edge.
REQ-014 clk_out SHALL be registered from the current C: 0 when C<=H and 1 when C>H, giving a 50% duty cycle and one cycle of latency.
REQ-015 tick SHALL assert for exactly one cycle, registered in the same cycle that clk_out goes from 0 to 1.
REQ-016 load=1 SHALL capture half_cycle into S and set P; a load while P is already set SHALL overwrite S (the latest value wins).
REQ-017 A pending S SHALL become H only at the wrap cycle (C==D), so there is no truncated or stretched half period; C restarts at 1 and load_ack pulses in the same cycle.
REQ-018 If the channel is idle (enable=0 or H==0), a pending S SHALL be applied on the next clock edge and load_ack SHALL pulse.
REQ-019 If load and the wrap/apply cycle coincide, the old S SHALL be applied, the new value SHALL go into S, and P SHALL remain set.
REQ-020 enable=0 SHALL force C to 1 and clk_out to 0 with no tick on the next edge; re-enabling SHALL start a fresh low half period.
REQ-021 H==0 SHALL hold clk_out at 0 with no ticks.
REQ-022 H==1 SHALL produce divide-by-2 output, alternating 0,1 on every cycle.
REQ-023 Channels SHALL be fully independent, with no shared counters or arbitration.

Reset
REQ-024 While rst_n=0 the block SHALL asynchronously clear H, S and P, set C to 1, and drive clk_out, tick and load_ack to 0.
REQ-025 Deasserting reset mid-operation SHALL leave every channel idle with H=0 until it is loaded; the register state SHALL be the same as after power-up.

Structure
REQ-026 Shared package clk_div_pkg SHALL hold the default CNT_W, the NUM_CH limit and the helper constant for counter width (CNT_W+1).
REQ-027 Sub-module clk_div_channel SHALL implement one channel; clk_div_bank SHALL instantiate it NUM_CH times in a generate loop.

Verification
REQ-028 Load H=2 on ch0 with enable=1 -> clk_out[0] repeats 0,0,1,1; tick every 4 cycles; load_ack pulses once.
REQ-029 H=3 running, load 5 mid-period -> the current 6-cycle period completes unchanged, load_ack pulses at the wrap, and the next period is 10 cycles (5 low, 5 high).
REQ-030 Loads of 4 then 7 within one period -> only 7 is applied at the wrap, with one load_ack; loading exactly on the wrap cycle keeps P=1 and applies the new value at the following wrap.
REQ-031 H=1 -> clk_out toggles every cycle; H=0 -> clk_out stays at 0 and tick is never asserted.
REQ-032 Drop enable mid-high-phase -> clk_out=0 on the next edge with no tick; re-enable with H=2 -> 2 low cycles, then high.
REQ-033 Assert rst_n=0 asynchronously mid-period on all channels with NUM_CH=4 -> all outputs go to 0 immediately, and they stay at 0 after release until reloaded.
